truth_table_sweeper: RTL and testbench

- Sequential harness for a single-output 5-input combinational stage. It drives every input combination A..E in ascending order to the stage.
- It samples the stage's output F on the next clock edge and assembles a 32-bit truth table and a ones count.
- It compares the result against a supplied golden table.
- In the design it sits as both upstream source and downstream consumer of the combinational stage, and it replaces free-running simulation sweeps with a synthesizable, handshaked checker.

---
 rtl/truth_table_sweeper.sv | 101 ++++++++++
 tb/tb_truth_table_sweeper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**NUM_IN input vectors through an external combinational stage,
// captures its truth table and ones count, and compares against a golden table.
module truth_table_sweeper #(
    parameter int NUM_IN        = 5,
    parameter int SETTLE_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     f_in,
    input  logic [(2**NUM_IN)-1:0]   expected_tt,
    output logic [NUM_IN-1:0]        abcde,
    output logic                     busy,
    output logic                     done,
    output logic [(2**NUM_IN)-1:0]   truth_table,
    output logic [NUM_IN:0]          ones_count,
    output logic                     match
);
    localparam int TT_W = 2**NUM_IN;
    localparam logic [3:0] SETTLE_RELOAD =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
    localparam logic [NUM_IN-1:0] LAST_VEC = NUM_IN'(TT_W - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t            state, state_n;
    logic [3:0]        settle_cnt;
    logic [TT_W-1:0]   exp_q;
    logic [TT_W-1:0]   tt_next;
    logic              start_acc;
    logic              smp;
    logic              last_vec;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_acc = 1'b0;
        smp       = 1'b0;
        last_vec  = (abcde == LAST_VEC);
        busy      = (state == SETTLE) || (state == SAMPLE);
        done      = (state == DONE);
        tt_next   = truth_table;
        tt_next[abcde] = f_in;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_n   = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) state_n = SAMPLE;
            end
            SAMPLE: begin
                smp = 1'b1;
                if (last_vec)                 state_n = DONE;
                else if (SETTLE_CYCLES == 0)  state_n = SAMPLE;
                else                          state_n = SETTLE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abcde       <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            settle_cnt  <= '0;
            exp_q       <= '0;
            match       <= 1'b0;
        end else if (start_acc) begin
            abcde       <= '0;
            truth_table <= '0;
            ones_count  <= '0;
            match       <= 1'b0;
            exp_q       <= expected_tt;
            settle_cnt  <= SETTLE_RELOAD;
        end else if (smp) begin
            truth_table <= tt_next;
            ones_count  <= ones_count + {{NUM_IN{1'b0}}, f_in};
            // Compare against the table including the bit being written this edge.
            if (last_vec) begin
                match <= (tt_next == exp_q);
            end else begin
                abcde      <= abcde + NUM_IN'(1);
                settle_cnt <= SETTLE_RELOAD;
            end
        end else if (state == SETTLE) begin
            if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
        end else if (state == DONE) begin
            abcde <= '0;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-driven sweeps, random tables against a
// bit-loop reference, plus reset-abort, start re-pulse and back-to-back cases.
module tb_truth_table_sweeper;
    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2;
    logic        f0, f2;
    logic [31:0] exp_in;
    logic [4:0]  abcde0, abcde2;
    logic        busy0, busy2, done0, done2, match0, match2;
    logic [31:0] tt0, tt2;
    logic [5:0]  ones0, ones2;

    int          errors = 0;
    int          checks = 0;
    int          mode;      // 0 formula stage, 1 tied 1, 2 tied 0, 3 random table
    logic [31:0] rtt;
    int          sel_v;

    always #5 clk = ~clk;

    truth_table_sweeper #(.NUM_IN(5), .SETTLE_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f0), .expected_tt(exp_in),
        .abcde(abcde0), .busy(busy0), .done(done0), .truth_table(tt0),
        .ones_count(ones0), .match(match0));

    truth_table_sweeper #(.NUM_IN(5), .SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .f_in(f2), .expected_tt(exp_in),
        .abcde(abcde2), .busy(busy2), .done(done2), .truth_table(tt2),
        .ones_count(ones2), .match(match2));

    // Behavioural model of the stage under test.
    function automatic logic stage_f(input int m, input logic [4:0] v, input logic [31:0] t);
        logic a, b, c, d, e;
        {a, b, c, d, e} = v;
        case (m)
            0:       return (a | ~b | c) & (~a | d) & (b | ~c | ~e);
            1:       return 1'b1;
            2:       return 1'b0;
            default: return t[v];
        endcase
    endfunction

    always_comb f0 = stage_f(mode, abcde0, rtt);
    always_comb f2 = stage_f(mode, abcde2, rtt);

    logic       done_s, busy_s, match_s;
    logic [4:0] abcde_s;
    logic [31:0] tt_s;
    logic [5:0] ones_s;
    always_comb begin
        done_s  = (sel_v == 0) ? done0  : done2;
        busy_s  = (sel_v == 0) ? busy0  : busy2;
        match_s = (sel_v == 0) ? match0 : match2;
        abcde_s = (sel_v == 0) ? abcde0 : abcde2;
        tt_s    = (sel_v == 0) ? tt0    : tt2;
        ones_s  = (sel_v == 0) ? ones0  : ones2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start2 = v;
    endtask

    // One complete sweep on the selected DUT with latency and sequence checks.
    task automatic sweep(input int sel, input logic [31:0] exp_tt, input logic [31:0] want_tt,
                         input int want_ones, input logic want_match, input bit repulse,
                         input string tag);
        int spc;
        int j;
        int bad_seq;
        int extra_done;
        bit seen;
        spc        = (sel == 0) ? 1 : 3;
        sel_v      = sel;
        bad_seq    = 0;
        extra_done = 0;
        seen       = 0;
        exp_in     = exp_tt;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        exp_in = ~exp_tt;          // golden table must already be latched
        check({tag, "_busy"}, busy_s, 1'b1);
        j = 0;
        while (!seen && j < 200) begin
            if (done_s) begin
                seen = 1;
            end else begin
                if (abcde_s != 5'(j / spc)) bad_seq++;
                set_start(sel, repulse && (j == 4 || j == 19));
                @(negedge clk);
                j++;
            end
        end
        set_start(sel, 1'b0);
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_latency"}, j + 1, 32 * spc + 1);
        check({tag, "_abcde_seq"}, bad_seq, 0);
        check({tag, "_tt"}, tt_s, want_tt);
        check({tag, "_ones"}, ones_s, want_ones);
        check({tag, "_match"}, match_s, want_match);
        check({tag, "_busy_done"}, busy_s, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done_s) extra_done++;
        end
        check({tag, "_single_done"}, extra_done, 0);
        check({tag, "_abcde_idle"}, abcde_s, 5'd0);
        check({tag, "_tt_hold"}, tt_s, want_tt);
        check({tag, "_match_hold"}, match_s, want_match);
    endtask

    typedef struct {
        int          sel;
        int          m;
        logic [31:0] exp_tt;
        logic [31:0] want_tt;
        int          want_ones;
        logic        want_match;
        bit          repulse;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   cnt;
        int   n;
        int   nd;
        int   last;
        logic [31:0] e;

        tbl[0] = '{0, 0, 32'hCC4CF05F, 32'hCC4CF05F, 17, 1'b1, 1'b0};
        tbl[1] = '{0, 0, 32'hCC4CF05E, 32'hCC4CF05F, 17, 1'b0, 1'b0};
        tbl[2] = '{2, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 1'b1, 1'b0};
        tbl[3] = '{2, 2, 32'h00000000, 32'h00000000, 0,  1'b1, 1'b0};
        tbl[4] = '{0, 1, 32'h00000000, 32'hFFFFFFFF, 32, 1'b0, 1'b0};
        tbl[5] = '{0, 0, 32'hCC4CF05F, 32'hCC4CF05F, 17, 1'b1, 1'b1};

        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; exp_in = '0;
        mode = 0; rtt = '0; sel_v = 0;
        repeat (3) @(negedge clk);
        check("rst_u0", {abcde0, busy0, done0, tt0, ones0, match0}, '0);
        check("rst_u2", {abcde2, busy2, done2, tt2, ones2, match2}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            mode = tbl[i].m;
            sweep(tbl[i].sel, tbl[i].exp_tt, tbl[i].want_tt, tbl[i].want_ones,
                  tbl[i].want_match, tbl[i].repulse, $sformatf("vec%0d", i));
        end

        // Random tables against the reference: popcount by bit loop.
        mode = 3;
        for (int r = 0; r < 6; r++) begin
            rtt = $urandom;
            e   = $urandom_range(0, 1) ? rtt : (rtt ^ (32'h1 << $urandom_range(0, 31)));
            cnt = 0;
            for (int b = 0; b < 32; b++) cnt += int'(rtt[b]);
            sweep(r % 2 == 0 ? 0 : 2, e, rtt, cnt, e == rtt, 1'b0, $sformatf("rnd%0d", r));
        end

        // Reset in mid-sweep aborts without a done pulse.
        mode = 0; sel_v = 0; exp_in = 32'hCC4CF05F;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        n = 0;
        while (abcde0 != 5'd12 && n < 100) begin @(negedge clk); n++; end
        check("abort_reach12", abcde0, 5'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {abcde0, busy0, done0, tt0, ones0}, '0);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done0) nd++; end
        check("abort_no_done", nd, 0);
        sweep(0, 32'hCC4CF05F, 32'hCC4CF05F, 17, 1'b1, 1'b0, "post_abort");

        // Back-to-back: start held high; each sweep begins in the IDLE cycle after DONE.
        mode = 0; exp_in = 32'hCC4CF05F;
        @(negedge clk); start0 = 1'b1;
        n = 0; nd = 0; last = -1;
        while (nd < 3 && n < 400) begin
            @(negedge clk); n++;
            if (done0) begin
                nd++;
                check($sformatf("b2b%0d_tt", nd), tt0, 32'hCC4CF05F);
                check($sformatf("b2b%0d_ones", nd), ones0, 17);
                check($sformatf("b2b%0d_match", nd), match0, 1'b1);
                if (last >= 0) check($sformatf("b2b%0d_gap", nd), n - last, 34);
                last = n;
                @(negedge clk); n++;
                check($sformatf("b2b%0d_hold", nd), {busy0, done0, tt0, ones0, match0},
                      {1'b0, 1'b0, 32'hCC4CF05F, 6'd17, 1'b1});
                if (nd == 3) start0 = 1'b0;
            end
        end
        check("b2b_count", nd, 3);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done0 || busy0) nd++; end
        check("b2b_stopped", nd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
